camera_pixel_assembler: RTL

Parametrised successor to the camera byte-to-pixel reconstructor. It samples a DVP-style 8-bit camera bus (pclk/hs/vs/data) in the system clock domain and assembles 1–3 bytes into one pixel, in a selectable byte order. It emits each pixel with line and pixel coordinates, a frame-start flag, a partial-pixel error flag and a frame counter. It sits between the camera pins and the frame buffer writer.

---
 rtl/camera_pkg.sv | 11 +
 rtl/sync_chain.sv | 31 +++
 rtl/camera_pixel_assembler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared types and limits for the camera pixel assembler.
package camera_pkg;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    localparam int MAX_BYTES_PER_PIXEL = 3;

endpackage

// File: rtl/sync_chain.sv
// Parametrised multi-flop synchronizer; every bit of the bus sees the same
// depth so bundled signals stay mutually aligned.
module sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] synced
);

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_in) begin
                if (rst_in) q_reg <= '0;
                else        q_reg <= data;
            end
        end else begin : g_next
            always_ff @(posedge clk_in) begin
                if (rst_in) q_reg <= '0;
                else        q_reg <= g_stage[gi-1].q_reg;
            end
        end
    end

    assign synced = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/camera_pixel_assembler.sv
// Samples a DVP camera bus in the system clock domain and assembles 1-3 bytes
// per pixel, tagging each pixel with line/pixel coordinates and frame flags.
module camera_pixel_assembler
    import camera_pkg::*;
#(
    parameter int BYTES_PER_PIXEL   = 2,
    parameter int HCOUNT_WIDTH      = 11,
    parameter int VCOUNT_WIDTH      = 10,
    parameter int SYNC_STAGES       = 2,
    parameter int FRAME_COUNT_WIDTH = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         camera_pclk_in,
    input  logic                         camera_hs_in,
    input  logic                         camera_vs_in,
    input  logic [7:0]                   camera_data_in,
    input  logic                         swap_bytes_in,
    output logic                         pixel_valid_out,
    output logic [HCOUNT_WIDTH-1:0]      pixel_hcount_out,
    output logic [VCOUNT_WIDTH-1:0]      pixel_vcount_out,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
    output logic                         frame_start_out,
    output logic                         line_error_out,
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count_out
);

    localparam int PIX_W    = 8 * BYTES_PER_PIXEL;
    localparam int CNT_W    = $clog2(MAX_BYTES_PER_PIXEL);
    localparam int SLOTS    = (BYTES_PER_PIXEL > 1) ? BYTES_PER_PIXEL - 1 : 1;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic [10:0] sync_bus;
    logic        pclk_s, hs_s, vs_s;
    logic [7:0]  data_s;

    sync_chain #(
        .WIDTH (11),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .data   ({camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in}),
        .synced (sync_bus)
    );

    assign {pclk_s, hs_s, vs_s, data_s} = sync_bus;

    // Edge-detect stage: registered events feed the FSM one cycle later.
    logic                pclk_prev_reg, hs_prev_reg, vs_prev_reg;
    logic                sample_ev_reg, hs_rise_ev_reg, hs_fall_ev_reg;
    logic                vs_rise_ev_reg, vs_fall_ev_reg;
    logic [7:0]          data_ev_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;
    logic                armed_reg;
    logic                settle_done;

    assign settle_done = (settle_cnt_reg == SETTLE_W'(SYNC_STAGES));

    // A vs rise only counts once vs has been seen low after the chain refilled,
    // so a frame already in progress when reset drops is skipped entirely.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pclk_prev_reg  <= 1'b0;
            hs_prev_reg    <= 1'b0;
            vs_prev_reg    <= 1'b0;
            sample_ev_reg  <= 1'b0;
            hs_rise_ev_reg <= 1'b0;
            hs_fall_ev_reg <= 1'b0;
            vs_rise_ev_reg <= 1'b0;
            vs_fall_ev_reg <= 1'b0;
            data_ev_reg    <= '0;
            settle_cnt_reg <= '0;
            armed_reg      <= 1'b0;
        end else begin
            pclk_prev_reg  <= pclk_s;
            hs_prev_reg    <= hs_s;
            vs_prev_reg    <= vs_s;
            sample_ev_reg  <= pclk_s & ~pclk_prev_reg & hs_s & vs_s;
            hs_rise_ev_reg <= hs_s & ~hs_prev_reg;
            hs_fall_ev_reg <= ~hs_s & hs_prev_reg;
            vs_rise_ev_reg <= vs_s & ~vs_prev_reg & armed_reg;
            vs_fall_ev_reg <= ~vs_s & vs_prev_reg;
            data_ev_reg    <= data_s;
            if (!settle_done) settle_cnt_reg <= settle_cnt_reg + 1'b1;
            if (settle_done && !vs_s) armed_reg <= 1'b1;
        end
    end

    // Byte assembly: earlier bytes come from slots, the completing one is live.
    logic [7:0]       slot_reg [SLOTS];
    logic [PIX_W-1:0] pix_msb_first, pix_lsb_first;

    genvar gi;
    for (gi = 0; gi < BYTES_PER_PIXEL; gi++) begin : g_bytes
        logic [7:0] byte_val;
        if (gi == BYTES_PER_PIXEL - 1) begin : g_last
            assign byte_val = data_ev_reg;
        end else begin : g_slot
            assign byte_val = slot_reg[gi];
        end
        assign pix_msb_first[8*(BYTES_PER_PIXEL-1-gi) +: 8] = byte_val;
        assign pix_lsb_first[8*gi +: 8]                    = byte_val;
    end

    state_t                       state_reg;
    logic                         swap_reg, first_pending_reg, line_has_pix_reg;
    logic [CNT_W-1:0]             byte_cnt_reg, byte_cnt_eff;
    logic [HCOUNT_WIDTH-1:0]      hcount_reg, hcount_eff;
    logic [VCOUNT_WIDTH-1:0]      vcount_reg;
    logic [FRAME_COUNT_WIDTH-1:0] frame_cnt_reg;
    logic                         emit_reg, start_reg, err_reg;
    logic [PIX_W-1:0]             pix_data_reg;
    logic [HCOUNT_WIDTH-1:0]      pix_h_reg;
    logic [VCOUNT_WIDTH-1:0]      pix_v_reg;

    // A sample landing with the hs rise belongs to the new line.
    assign byte_cnt_eff = hs_rise_ev_reg ? '0 : byte_cnt_reg;
    assign hcount_eff   = hs_rise_ev_reg ? '0 : hcount_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg         <= WAIT_FRAME;
            swap_reg          <= 1'b0;
            first_pending_reg <= 1'b0;
            line_has_pix_reg  <= 1'b0;
            byte_cnt_reg      <= '0;
            hcount_reg        <= '0;
            vcount_reg        <= '0;
            frame_cnt_reg     <= '0;
            emit_reg          <= 1'b0;
            start_reg         <= 1'b0;
            err_reg           <= 1'b0;
            pix_data_reg      <= '0;
            pix_h_reg         <= '0;
            pix_v_reg         <= '0;
            for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
        end else begin
            emit_reg  <= 1'b0;
            start_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                WAIT_FRAME: begin
                    if (vs_rise_ev_reg) begin
                        state_reg         <= ACTIVE;
                        swap_reg          <= swap_bytes_in;
                        hcount_reg        <= '0;
                        vcount_reg        <= '0;
                        byte_cnt_reg      <= '0;
                        first_pending_reg <= 1'b1;
                        line_has_pix_reg  <= 1'b0;
                        frame_cnt_reg     <= frame_cnt_reg + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (vs_fall_ev_reg) begin
                        state_reg    <= WAIT_FRAME;
                        byte_cnt_reg <= '0;
                    end else begin
                        if (hs_rise_ev_reg) begin
                            byte_cnt_reg     <= '0;
                            hcount_reg       <= '0;
                            line_has_pix_reg <= 1'b0;
                        end
                        if (hs_fall_ev_reg) begin
                            if (byte_cnt_reg != '0) err_reg <= 1'b1;
                            byte_cnt_reg <= '0;
                            if (line_has_pix_reg && vcount_reg != '1)
                                vcount_reg <= vcount_reg + 1'b1;
                        end
                        if (sample_ev_reg) begin
                            if (byte_cnt_eff == CNT_W'(BYTES_PER_PIXEL - 1)) begin
                                emit_reg          <= 1'b1;
                                pix_data_reg      <= swap_reg ? pix_lsb_first : pix_msb_first;
                                pix_h_reg         <= hcount_eff;
                                pix_v_reg         <= vcount_reg;
                                start_reg         <= first_pending_reg;
                                first_pending_reg <= 1'b0;
                                line_has_pix_reg  <= 1'b1;
                                byte_cnt_reg      <= '0;
                                hcount_reg        <= (hcount_eff == '1) ? hcount_eff
                                                                        : hcount_eff + 1'b1;
                            end else begin
                                for (int i = 0; i < SLOTS; i++)
                                    if (byte_cnt_eff == CNT_W'(i)) slot_reg[i] <= data_ev_reg;
                                byte_cnt_reg <= byte_cnt_eff + 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= WAIT_FRAME;
            endcase
        end
    end

    // Output stage: strobes are single-cycle, pixel fields hold between strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_valid_out  <= 1'b0;
            frame_start_out  <= 1'b0;
            line_error_out   <= 1'b0;
            pixel_data_out   <= '0;
            pixel_hcount_out <= '0;
            pixel_vcount_out <= '0;
        end else begin
            pixel_valid_out <= emit_reg;
            frame_start_out <= start_reg;
            line_error_out  <= err_reg;
            if (emit_reg) begin
                pixel_data_out   <= pix_data_reg;
                pixel_hcount_out <= pix_h_reg;
                pixel_vcount_out <= pix_v_reg;
            end
        end
    end

    assign frame_count_out = frame_cnt_reg;

endmodule
